// File: rtl/sr_trace_buffer_if.sv
// Trace/trigger/readout bundle for sr_trace_buffer: the core and debug host
// drive the master side, the capture buffer sits on the slave side.
interface sr_trace_buffer_if #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             trace_valid;
  logic [31:0]      trace_pc;
  logic [31:0]      trace_instr;
  logic             trace_rd_we;
  logic [4:0]       trace_rd;
  logic [31:0]      trace_rd_data;
  logic             arm;
  logic [1:0]       trig_mode;
  logic [31:0]      trig_pc;
  logic [31:0]      trig_instr;
  logic [31:0]      trig_mask;
  logic             trig_force;
  logic [AW-1:0]    post_count;
  logic [AW-1:0]    rd_idx;
  logic [CYC_W-1:0] rd_cycle;
  logic [31:0]      rd_pc;
  logic [31:0]      rd_instr;
  logic [37:0]      rd_wb;
  logic [1:0]       state;
  logic [AW:0]      count;
  logic [AW-1:0]    trig_idx;
  logic             timeout;

  modport master (
    output trace_valid, trace_pc, trace_instr, trace_rd_we, trace_rd, trace_rd_data,
    output arm, trig_mode, trig_pc, trig_instr, trig_mask, trig_force, post_count, rd_idx,
    input  rd_cycle, rd_pc, rd_instr, rd_wb, state, count, trig_idx, timeout
  );

  modport slave (
    input  trace_valid, trace_pc, trace_instr, trace_rd_we, trace_rd, trace_rd_data,
    input  arm, trig_mode, trig_pc, trig_instr, trig_mask, trig_force, post_count, rd_idx,
    output rd_cycle, rd_pc, rd_instr, rd_wb, state, count, trig_idx, timeout
  );
endinterface

// File: rtl/sr_trace_buffer.sv
// Instruction-retire trace capture for schoolRISCV: circular buffer with a
// trigger + post-trigger stop, frozen readout and a sticky stall watchdog.
module sr_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  sr_trace_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      CNT_FULL = DEPTH[AW:0];
  localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    IDLE_ONE = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]    TMO_LIM  = TIMEOUT[TW-1:0];
  localparam logic [TW-1:0]    TMO_PRE  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
  localparam logic             TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t           state_r;
  logic [AW:0]      count_r;
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    postCnt_r;
  logic [AW-1:0]    trigIdx_r;
  logic [CYC_W-1:0] cycleCnt_r;
  logic [TW-1:0]    idleCnt_r;
  logic             timeout_r;
  logic [CYC_W-1:0] rdCycle_r;
  logic [31:0]      rdPc_r;
  logic [31:0]      rdInstr_r;
  logic [37:0]      rdWb_r;

  logic [CYC_W-1:0] memCycle [DEPTH];
  logic [31:0]      memPc    [DEPTH];
  logic [31:0]      memInstr [DEPTH];
  logic [37:0]      memWb    [DEPTH];

  logic             modeMatch_s;
  logic             trigHit_s;
  logic             wrEn_s;
  logic [AW-1:0]    remain_s;
  logic [AW-1:0]    trigIdxNext_s;
  logic [AW-1:0]    rdAddr_s;

  // Trigger match, write enable, trigger index and readout address decode
  always_comb begin
    modeMatch_s   = 1'b0;
    trigHit_s     = 1'b0;
    wrEn_s        = 1'b0;
    remain_s      = ~bus.post_count;
    trigIdxNext_s = {AW{1'b0}};
    rdAddr_s      = wrPtr_r - count_r[AW-1:0] + bus.rd_idx;

    case (bus.trig_mode)
      2'd0:    modeMatch_s = 1'b1;
      2'd1:    modeMatch_s = (bus.trace_pc == bus.trig_pc);
      2'd2:    modeMatch_s = ((bus.trace_instr & bus.trig_mask) == bus.trig_instr);
      2'd3:    modeMatch_s = 1'b0;
      default: modeMatch_s = 1'b0;
    endcase

    trigHit_s = (bus.trace_valid && modeMatch_s) || bus.trig_force;

    if (bus.trace_valid && !bus.arm && (state_r == ARMED || state_r == TRIGGERED)) begin
      wrEn_s = 1'b1;
    end else begin
      wrEn_s = 1'b0;
    end

    // Index in the frozen buffer: older entries scroll out while the
    // post-trigger entries fill a full buffer, so clamp to DEPTH-1-post_count.
    if (count_r >= {1'b0, remain_s}) begin
      trigIdxNext_s = remain_s;
    end else begin
      trigIdxNext_s = count_r[AW-1:0];
    end
  end

  // Capture control FSM: pointers, fill count, post-trigger countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= {(AW+1){1'b0}};
      wrPtr_r   <= {AW{1'b0}};
      postCnt_r <= {AW{1'b0}};
      trigIdx_r <= {AW{1'b0}};
    end else if (bus.arm) begin
      state_r   <= ARMED;
      count_r   <= {(AW+1){1'b0}};
      wrPtr_r   <= {AW{1'b0}};
      postCnt_r <= {AW{1'b0}};
    end else begin
      if (wrEn_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
        if (count_r != CNT_FULL) begin
          count_r <= count_r + CNT_ONE;
        end
      end
      case (state_r)
        IDLE: state_r <= IDLE;
        ARMED: begin
          if (trigHit_s) begin
            trigIdx_r <= trigIdxNext_s;
            if (bus.post_count == {AW{1'b0}}) begin
              state_r <= DONE;
            end else begin
              state_r   <= TRIGGERED;
              postCnt_r <= bus.post_count;
            end
          end
        end
        TRIGGERED: begin
          if (wrEn_s) begin
            postCnt_r <= postCnt_r - PTR_ONE;
            if (postCnt_r == PTR_ONE) begin
              state_r <= DONE;
            end
          end
        end
        DONE: state_r <= DONE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Trace storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wrEn_s) begin
      memCycle[wrPtr_r] <= cycleCnt_r;
      memPc[wrPtr_r]    <= bus.trace_pc;
      memInstr[wrPtr_r] <= bus.trace_instr;
      memWb[wrPtr_r]    <= {bus.trace_rd_we, bus.trace_rd, bus.trace_rd_data};
    end
  end

  // Free-running cycle stamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCnt_r <= {CYC_W{1'b0}};
    end else begin
      cycleCnt_r <= cycleCnt_r + CYC_ONE;
    end
  end

  // Registered readout, oldest-relative index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdCycle_r <= {CYC_W{1'b0}};
      rdPc_r    <= 32'h0000_0000;
      rdInstr_r <= 32'h0000_0000;
      rdWb_r    <= 38'h0;
    end else begin
      rdCycle_r <= memCycle[rdAddr_s];
      rdPc_r    <= memPc[rdAddr_s];
      rdInstr_r <= memInstr[rdAddr_s];
      rdWb_r    <= memWb[rdAddr_s];
    end
  end

  // Stall watchdog; flag sets on the cycle the idle run reaches TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idleCnt_r <= {TW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (bus.trace_valid) begin
        idleCnt_r <= {TW{1'b0}};
      end else if (idleCnt_r != TMO_LIM) begin
        idleCnt_r <= idleCnt_r + IDLE_ONE;
      end
      if (bus.arm) begin
        timeout_r <= 1'b0;
      end else if (TMO_EN && !bus.trace_valid && idleCnt_r == TMO_PRE) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign bus.state    = state_r;
  assign bus.count    = count_r;
  assign bus.trig_idx = trigIdx_r;
  assign bus.timeout  = timeout_r;
  assign bus.rd_cycle = rdCycle_r;
  assign bus.rd_pc    = rdPc_r;
  assign bus.rd_instr = rdInstr_r;
  assign bus.rd_wb    = rdWb_r;
endmodule

// File: tb/tb_sr_trace_buffer.sv
// Directed self-checking bench for sr_trace_buffer (DEPTH=16, TIMEOUT=5).
module tb_sr_trace_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sr_trace_buffer_if #(.DEPTH(16), .CYC_W(16)) bus ();

  sr_trace_buffer #(.DEPTH(16), .CYC_W(16), .TIMEOUT(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    bus.trace_valid   = 1'b1;
    bus.trace_pc      = pc;
    bus.trace_instr   = instr;
    bus.trace_rd_we   = 1'b1;
    bus.trace_rd      = pc[6:2];
    bus.trace_rd_data = pc ^ 32'hA5A5_0000;
    tick();
    bus.trace_valid   = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [3:0] post);
    bus.trig_mode  = mode;
    bus.post_count = post;
    bus.arm        = 1'b1;
    tick();
    bus.arm        = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] c0;
    rst = 1'b1;
    #3;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if ({bus.trig_idx, bus.timeout, bus.rd_pc, bus.rd_instr} !== 69'd0) begin errors++; $display("FAIL reset_outs got %h want 0", {bus.trig_idx, bus.timeout, bus.rd_pc, bus.rd_instr}); end
    tick();
    rst = 1'b0;
    c0 = 16'd0;
    retire(32'h0, 32'h13);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL idle_no_capture got %0d want 0", bus.count); end
  endtask

  task automatic test_immediate();
    logic [15:0] cyc0;
    do_arm(2'd0, 4'd3);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL t1_armed got %0d want 1", bus.state); end
    retire(32'h00, 32'h13);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL t1_triggered got %0d want 2", bus.state); end
    retire(32'h04, 32'h13);
    retire(32'h08, 32'h13);
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL t1_still_trig got %0d want 2", bus.state); end
    retire(32'h0C, 32'h13);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL t1_done got %0d want 3", bus.state); end
    retire(32'h10, 32'h13);
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL t1_count got %0d want 4", bus.count); end
    checks++; if (bus.trig_idx !== 4'd0) begin errors++; $display("FAIL t1_trig_idx got %0d want 0", bus.trig_idx); end
    cyc0 = 16'd0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_idx = i[3:0];
      tick();
      checks++; if (bus.rd_pc !== 32'(i * 4)) begin errors++; $display("FAIL t1_rd_pc%0d got %h want %h", i, bus.rd_pc, 32'(i * 4)); end
      if (i == 0) cyc0 = bus.rd_cycle;
      if (i == 1) begin
        checks++; if (bus.rd_cycle !== cyc0 + 16'd1) begin errors++; $display("FAIL t1_stamp got %0d want %0d", bus.rd_cycle, cyc0 + 16'd1); end
      end
    end
    checks++; if (bus.rd_wb !== {1'b1, 5'd3, 32'hA5A5_000C}) begin errors++; $display("FAIL t1_rd_wb got %h want %h", bus.rd_wb, {1'b1, 5'd3, 32'hA5A5_000C}); end
  endtask

  task automatic test_pc_wrap();
    bus.trig_pc = 32'h80;
    do_arm(2'd1, 4'd2);
    for (int p = 0; p <= 32'hA0; p += 4) begin
      retire(32'(p), 32'h13);
    end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL t2_done got %0d want 3", bus.state); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL t2_count got %0d want 16", bus.count); end
    checks++; if (bus.trig_idx !== 4'd13) begin errors++; $display("FAIL t2_trig_idx got %0d want 13", bus.trig_idx); end
    bus.rd_idx = 4'd15;
    tick();
    checks++; if (bus.rd_pc !== 32'h88) begin errors++; $display("FAIL t2_rd15 got %h want 88", bus.rd_pc); end
    bus.rd_idx = 4'd0;
    tick();
    checks++; if (bus.rd_pc !== 32'h4C) begin errors++; $display("FAIL t2_rd0 got %h want 4c", bus.rd_pc); end
    bus.rd_idx = 4'd13;
    tick();
    checks++; if (bus.rd_pc !== 32'h80) begin errors++; $display("FAIL t2_rd_trig got %h want 80", bus.rd_pc); end
  endtask

  task automatic test_instr_match();
    bus.trig_mask  = 32'h0000_007F;
    bus.trig_instr = 32'h0000_0063;
    do_arm(2'd2, 4'd0);
    for (int p = 0; p < 32'h24; p += 4) begin
      retire(32'(p), 32'h0010_0093);
    end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL t3_armed got %0d want 1", bus.state); end
    retire(32'h24, 32'h0000_0463);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL t3_done got %0d want 3", bus.state); end
    checks++; if (bus.count !== 5'd10) begin errors++; $display("FAIL t3_count got %0d want 10", bus.count); end
    checks++; if (bus.trig_idx !== 4'd9) begin errors++; $display("FAIL t3_trig_idx got %0d want 9", bus.trig_idx); end
    bus.rd_idx = 4'd9;
    tick();
    checks++; if (bus.rd_pc !== 32'h24) begin errors++; $display("FAIL t3_rd_pc got %h want 24", bus.rd_pc); end
    checks++; if (bus.rd_instr[6:0] !== 7'h63) begin errors++; $display("FAIL t3_opcode got %h want 63", bus.rd_instr[6:0]); end
  endtask

  task automatic test_force();
    do_arm(2'd3, 4'd1);
    retire(32'h100, 32'h0000_0063);
    retire(32'h104, 32'h13);
    checks++; if (bus.state !== 2'd1 || bus.count !== 5'd2) begin errors++; $display("FAIL t4_manual_only got %0d/%0d want 1/2", bus.state, bus.count); end
    bus.trig_force = 1'b1;
    tick();
    bus.trig_force = 1'b0;
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL t4_triggered got %0d want 2", bus.state); end
    checks++; if (bus.trig_idx !== 4'd2) begin errors++; $display("FAIL t4_trig_idx got %0d want 2", bus.trig_idx); end
    retire(32'h108, 32'h13);
    checks++; if (bus.state !== 2'd3 || bus.count !== 5'd3) begin errors++; $display("FAIL t4_done got %0d/%0d want 3/3", bus.state, bus.count); end
    bus.rd_idx = bus.trig_idx;
    tick();
    checks++; if (bus.rd_pc !== 32'h108) begin errors++; $display("FAIL t4_rd_trig got %h want 108", bus.rd_pc); end
  endtask

  task automatic test_watchdog();
    bus.trig_mode   = 2'd3;
    bus.arm         = 1'b1;
    bus.trace_valid = 1'b1;
    tick();
    bus.arm         = 1'b0;
    bus.trace_valid = 1'b0;
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL t5_cleared got %0d want 0", bus.timeout); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL t5_early got %0d want 0", bus.timeout); end
    tick();
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL t5_set got %0d want 1", bus.timeout); end
    retire(32'h200, 32'h13);
    retire(32'h204, 32'h13);
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL t5_sticky got %0d want 1", bus.timeout); end
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL t5_arm_clear got %0d want 0", bus.timeout); end
  endtask

  task automatic test_arm_priority_and_reset();
    bus.trig_pc = 32'h300;
    do_arm(2'd1, 4'd3);
    retire(32'h2F0, 32'h13);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL t6_pre_count got %0d want 1", bus.count); end
    bus.arm = 1'b1;
    retire(32'h300, 32'h13);
    bus.arm = 1'b0;
    checks++; if (bus.state !== 2'd1 || bus.count !== 5'd0) begin errors++; $display("FAIL t6_arm_prio got %0d/%0d want 1/0", bus.state, bus.count); end
    retire(32'h300, 32'h13);
    checks++; if (bus.state !== 2'd2 || bus.count !== 5'd1) begin errors++; $display("FAIL t6_trig got %0d/%0d want 2/1", bus.state, bus.count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.state !== 2'd0 || bus.count !== 5'd0) begin errors++; $display("FAIL t6_async_rst got %0d/%0d want 0/0", bus.state, bus.count); end
    tick();
    rst = 1'b0;
    retire(32'h300, 32'h13);
    checks++; if (bus.state !== 2'd0 || bus.count !== 5'd0) begin errors++; $display("FAIL t6_post_rst got %0d/%0d want 0/0", bus.state, bus.count); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    bus.trace_valid   = 1'b0;
    bus.trace_pc      = 32'h0;
    bus.trace_instr   = 32'h0;
    bus.trace_rd_we   = 1'b0;
    bus.trace_rd      = 5'd0;
    bus.trace_rd_data = 32'h0;
    bus.arm           = 1'b0;
    bus.trig_mode     = 2'd0;
    bus.trig_pc       = 32'h0;
    bus.trig_instr    = 32'h0;
    bus.trig_mask     = 32'h0;
    bus.trig_force    = 1'b0;
    bus.post_count    = 4'd0;
    bus.rd_idx        = 4'd0;
    test_reset();
    test_immediate();
    test_pc_wrap();
    test_instr_match();
    test_force();
    test_watchdog();
    test_arm_priority_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_trace_buffer.md
Name: sr_trace_buffer

Overview:
Synthesizable instruction-retire trace capture for the schoolRISCV core, the hardware successor to the simulation-only per-cycle debug print and timeout.
- Records retired instructions in a DEPTH-entry circular buffer: cycle stamp, pc, instr and register writeback.
- Stops on a configurable trigger plus a post-trigger count, then freezes for readout.
- Provides a sticky stall watchdog that reports when no instruction retires for TIMEOUT cycles.

Parameters:
DEPTH, 16, buffer entries; power of two, minimum 4; AW = log2(DEPTH)
CYC_W, 16, width of cycle stamp and cycle counter
TIMEOUT, 1000, cycles without a retire before timeout sets; 0 disables the watchdog

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
trace_valid  in  1  one instruction retires this cycle
trace_pc  in  32  pc of retiring instruction
trace_instr  in  32  instruction word
trace_rd_we  in  1  retiring instruction writes rd
trace_rd  in  5  destination register
trace_rd_data  in  32  writeback value
arm  in  1  single-cycle pulse: clear the buffer, enter ARMED
trig_mode  in  2  0 = immediate, 1 = pc == trig_pc, 2 = instr & trig_mask == trig_instr, 3 = manual only
trig_pc  in  32  pc compare value
trig_instr  in  32  instruction compare value
trig_mask  in  32  instruction compare mask
trig_force  in  1  manual trigger, valid in any mode
post_count  in  AW  entries to capture after the trigger entry
rd_idx  in  AW  readout index; 0 = oldest valid entry
rd_cycle  out  CYC_W  registered readout: cycle stamp
rd_pc  out  32  registered readout: pc
rd_instr  out  32  registered readout: instruction
rd_wb  out  38  registered readout: {rd_we, rd, rd_data}
state  out  2  0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
count  out  AW+1  valid entries, saturates at DEPTH
trig_idx  out  AW  readout index of the trigger entry
timeout  out  1  sticky watchdog flag

Behaviour:
Reset:
- state = IDLE; count, wr_ptr, post counter, cycle counter, idle counter, trig_idx, timeout and all rd_* outputs = 0.
- Buffer contents need no reset.
- Reset asserted mid-capture aborts the capture and returns to IDLE.

Cycle counter:
- Free-running, increments every cycle, wraps modulo 2^CYC_W.
- The value in the retire cycle is stored as the entry stamp.

Capture:
- An entry is written only when trace_valid = 1 and state is ARMED or TRIGGERED.
- Write at wr_ptr, then wr_ptr++ (wraps at DEPTH); count++ until it saturates at DEPTH.
- Once full, the oldest entry is overwritten.

FSM:
- IDLE: arm -> ARMED.
- ARMED: a trigger is trace_valid together with the trig_mode match, or trig_force regardless of trace_valid.
  - Trigger with trace_valid = 1: that instruction is the trigger entry; latch trig_idx = readout index of that entry.
  - post_count = 0 -> DONE; otherwise -> TRIGGERED with post counter = post_count.
  - Forced trigger with no valid retire: trig_idx = index the next entry will occupy; -> TRIGGERED, or DONE if post_count = 0.
- TRIGGERED: each captured entry decrements the post counter; the write that brings it to 0 moves to DONE.
- DONE: writes blocked, contents frozen. arm -> ARMED.
- arm in any state, including ARMED or TRIGGERED:
  - count = 0, wr_ptr = 0, state = ARMED; the same-cycle retire is not captured and no trigger is evaluated that cycle.
  - arm has priority over any simultaneous trigger or write.
- Mode 0 triggers on the first valid retire after arm.
- post_count >= DEPTH-1 is legal; older entries, including the trigger entry, may then be overwritten. trig_idx is not updated for this.

Readout:
- Physical address = (wr_ptr - count + rd_idx) mod DEPTH.
- rd_* outputs are registered: 1-cycle latency in every state.
- rd_idx >= count returns the stale/undefined entry; it is not an error.

Watchdog:
- The idle counter clears on trace_valid and otherwise increments, saturating.
- When it reaches TIMEOUT, timeout sets and stays set until rst or arm.
- TIMEOUT = 0 keeps timeout at 0.

Test Plan:
1. Reset, arm, trig_mode=0, post_count=3, retire pc 0x00,0x04,0x08,0x0C,0x10 -> DONE after 4th retire; count=4; trig_idx=0; rd_idx 0..3 give pc 0x00..0x0C one cycle after each index; 5th retire not stored.
2. DEPTH=16, trig_mode=1, trig_pc=0x80, post_count=2, retire pc 0x00..0xA0 step 4 -> count=16; trig_idx=13; rd_idx=15 gives pc 0x88; rd_idx=0 gives pc 0x4C (wrap).
3. trig_mode=2, trig_mask=0x0000007F, trig_instr=0x00000063 (branch), post_count=0, stream of addi then beq at pc 0x24 -> DONE the same cycle beq retires; last entry pc=0x24 with instr bits[6:0]=0x63.
4. Armed, trig_mode=3, trig_force pulsed with trace_valid=0, post_count=1 -> TRIGGERED; next retire is captured and moves to DONE; trig_idx points at that entry.
5. TIMEOUT=5, no trace_valid for 5 cycles -> timeout=1 on the 5th and it stays 1 after later retires; arm clears it.
6. arm and a trigger-matching retire in the same cycle -> ARMED, count=0; rst asserted in TRIGGERED -> state=0 and count=0 immediately, without waiting for a clock edge.
